// File: rtl/mem_access_unit_pkg.sv
// rv32i_types: shared MEM-stage state encoding, load/store funct3 codes and access-size decode
package rv32i_types;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  function automatic logic [1:0] load_size(input logic [2:0] f);
    return (f == F3_LB || f == F3_LBU) ? SZ_B : (f == F3_LH || f == F3_LHU) ? SZ_H : SZ_W;
  endfunction
  function automatic logic [1:0] store_size(input logic [2:0] f);
    return f == F3_SB ? SZ_B : f == F3_SH ? SZ_H : SZ_W;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: picks the addressed lane of a read word and sign/zero-extends it (rdata, funct3, offset -> data)
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);
  logic [31:0] sh;
  logic [1:0]  sz;
  assign sh = rdata >> {offset, 3'b000};
  assign sz = load_size(funct3);
  assign data = sz == SZ_B ? {{24{sh[7] & ~funct3[2]}}, sh[7:0]}
              : sz == SZ_H ? {{16{sh[15] & ~funct3[2]}}, sh[15:0]}
              : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer (IDLE/ACCESS/DONE) with lane steering; ports: clk, rst_n, op_valid, flush, mem_read, mem_write, funct3, addr, store_data in; dmem_* request out, dmem_resp/dmem_rdata in; load_data, mem_stall, misaligned out; MEM_MISALIGN_TRAP_EN enables misalignment trapping
module mem_access_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        flush,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        misaligned
);
  mem_state_t  state;
  logic        a_read;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_data, fmt;
  logic [1:0]  sz, a_sz, off;
  logic        req, mis, launch, access;
  // rst_n gates the launch so nothing is requested or stalled while reset is held
  assign req = rst_n & op_valid & ~flush & (mem_read | mem_write);
  assign sz  = mem_read ? load_size(funct3) : store_size(funct3);
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = req && state == IDLE && (sz == SZ_H ? addr[0] : (sz == SZ_W && |addr[1:0]));
`else
  assign mis = 1'b0;
`endif
  assign launch    = state == IDLE && req && !mis;
  assign access    = state == ACCESS;
  assign mem_stall = launch | access;
  // The request is latched at launch so flush or upstream changes cannot disturb an access in flight
  assign a_sz = a_read ? load_size(a_f3) : store_size(a_f3);
  // Lane offset with sub-size address bits dropped (forced alignment)
  assign off  = a_sz == SZ_B ? a_addr[1:0] : a_sz == SZ_H ? {a_addr[1], 1'b0} : 2'b00;
  assign dmem_read        = access & a_read;
  assign dmem_write       = access & ~a_read;
  assign dmem_address     = access ? {a_addr[31:2], 2'b00} : 32'h0;
  assign dmem_byte_enable = !access ? 4'b0000 : a_sz == SZ_B ? 4'b0001 << off : a_sz == SZ_H ? 4'b0011 << off : 4'b1111;
  assign dmem_wdata       = dmem_write ? a_data << {off, 3'b000} : 32'h0;
  load_align u_align (
    .rdata  (dmem_rdata),
    .funct3 (a_f3),
    .offset (off),
    .data   (fmt)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_data  <= 32'h0;
      misaligned <= 1'b0;
      a_read     <= 1'b0;
      a_f3       <= 3'b000;
      a_addr     <= 32'h0;
      a_data     <= 32'h0;
    end else begin
      misaligned <= mis;
      state      <= launch ? ACCESS : access ? (dmem_resp ? DONE : ACCESS) : IDLE;
      if (launch) begin
        a_read <= mem_read;
        a_f3   <= funct3;
        a_addr <= addr;
        a_data <= store_data;
      end
      if (access && dmem_resp && a_read) load_data <= fmt;
    end
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (listed first).
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: op_valid  in  1  instruction present in MEM stage.
REQ-004 SHALL have ports: flush  in  1  squash current MEM-stage instruction.
REQ-005 SHALL have ports: mem_read / mem_write  in  1 each  access type, from the ctrl word.
REQ-006 SHALL have ports: funct3  in  3  access size and signedness.
REQ-007 SHALL have ports: addr  in  32  byte address (ALU result); store_data  in  32  rs2 value.
REQ-008 SHALL have ports: dmem_read / dmem_write  out  1 each; dmem_address  out  32; dmem_byte_enable  out  4; dmem_wdata  out  32.
REQ-009 SHALL have ports: dmem_resp  in  1; dmem_rdata  in  32.
REQ-010 SHALL have ports: load_data  out  32  formatted load result; mem_stall  out  1  hold upstream latches; misaligned  out  1  fault pulse.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-012 IDLE: if op_valid & !flush & (mem_read|mem_write), SHALL go to ACCESS next edge; otherwise stay IDLE.
REQ-013 ACCESS: SHALL hold dmem_read or dmem_write high, with address, enables and wdata stable, until dmem_resp; on the dmem_resp edge SHALL capture rdata and go to DONE.
REQ-014 DONE: SHALL drive no request, present load_data, and go to IDLE next edge.
REQ-015 mem_stall SHALL equal (IDLE & launch condition) | ACCESS; it SHALL be low in DONE.
REQ-016 Minimum latency SHALL be 3 cycles from accept to DONE with a same-cycle dmem_resp, plus one cycle per wait cycle.
REQ-017 dmem_address SHALL be {addr[31:2],2'b00}.
REQ-018 Store enables SHALL be: SB 4'b0001<<addr[1:0], SH 4'b0011<<{addr[1],1'b0}, SW 4'b1111.
REQ-019 dmem_wdata SHALL be store_data shifted left by 8*addr[1:0] for SB and SH, and unshifted for SW.
REQ-020 Loads SHALL select the lane by addr[1:0], then extend it: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-021 Unused funct3 codes SHALL format as LW or SW.
REQ-022 If mem_read & mem_write are both set, SHALL perform the read only.
REQ-023 flush while in ACCESS SHALL be ignored; the transaction completes.
REQ-024 load_data SHALL hold its value until the next captured read.
REQ-025 Non-memory instructions SHALL pass with zero stall.

Reset
REQ-026 When rst_n=0 at an edge: state IDLE, load_data 0, misaligned 0; all dmem outputs 0 and mem_stall 0 from that edge.
REQ-027 Reset in ACCESS SHALL drop the request at that edge; a late dmem_resp SHALL be ignored.

Configuration
REQ-028 Macro MEM_MISALIGN_TRAP_EN:
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL launch no access, pulse misaligned for one cycle, and not stall.
- Undefined: misaligned is tied 0; low address bits are ignored for that size (forced alignment).

Structure
REQ-029 Package rv32i_types SHALL hold the mem_state_t enum and the load/store funct3 constants.
REQ-030 Load lane select and extension SHALL be sub-module load_align (combinational).

Verification
REQ-031 SW addr=0x100, data=0xDEADBEEF, resp after 2 waits -> dmem_write with be=1111, wdata=0xDEADBEEF; stall for 4 cycles.
REQ-032 SB addr=0x103, data=0x000000A5 -> be=1000, wdata=0xA5000000, dmem_address=0x100.
REQ-033 LB addr=0x102, rdata=0x12F45678 -> load_data=0xFFFFFFF4; LBU gives 0x000000F4; LHU addr=0x102 gives 0x000012F4.
REQ-034 flush=1 with LW in IDLE -> no dmem_read, mem_stall=0; flush raised in ACCESS -> read still completes.
REQ-035 rst_n=0 in ACCESS -> dmem_read=0 next cycle, state IDLE; a dmem_resp one cycle later causes no change.
REQ-036 With MEM_MISALIGN_TRAP_EN, LW addr=0x102 -> misaligned pulses 1 cycle, no request; without it -> read of 0x100.
